// File: rtl/csr_timer_bank_pkg.sv
// Register map and TCFG field positions shared by the timer bank top level and its channels.
package csr_timer_bank_pkg;

  typedef enum logic [1:0] {
    REG_TCFG  = 2'd0,
    REG_TVAL  = 2'd1,
    REG_TICLR = 2'd2,
    REG_PRESC = 2'd3
  } csr_reg_e;

  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;

endpackage

// File: rtl/csr_timer_bank_timer_chan.sv
// One countdown channel: TCFG/TVAL/PRESC state, tick prescaler, and sticky interrupt.
module timer_chan
  import csr_timer_bank_pkg::*;
#(
  parameter int TIMER_W = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_cfg,
  input  logic               we_clr,
  input  logic               we_presc,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic [PRESC_W-1:0] presc,
  output logic               irq
);

  logic [TIMER_W-1:0] tcfg_reg;
  logic [TIMER_W-1:0] tval_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] cnt_reg;
  logic               armed_reg;
  logic               irq_reg;

  logic               tick;
  logic               expire;
  logic [TIMER_W-1:0] reload;

  // Live compare: lowering PRESC below the running count lets the count run on to all-ones and wrap.
  assign tick   = armed_reg && (cnt_reg == presc_reg);
  assign expire = tick && (tval_reg == '0);
  assign reload = {tcfg_reg[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_reg  <= '0;
      tval_reg  <= '0;
      presc_reg <= '0;
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      if (we_presc) begin
        presc_reg <= wdata[PRESC_W-1:0];
      end

      if (we_cfg) begin
        tcfg_reg  <= wdata;
        tval_reg  <= {wdata[TIMER_W-1:TCFG_INITVAL_LSB], 2'b00};
        cnt_reg   <= '0;
        armed_reg <= wdata[TCFG_EN];
      end else if (armed_reg) begin
        cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        if (tick) begin
          if (tval_reg != '0) begin
            tval_reg <= tval_reg - 1'b1;
          end else if (tcfg_reg[TCFG_PERIODIC]) begin
            tval_reg <= reload;
          end else begin
            tval_reg  <= '1;
            armed_reg <= 1'b0;
          end
        end
      end

      // A reconfigure swallows a coinciding expiry; otherwise set beats clear.
      if (expire && !we_cfg) begin
        irq_reg <= 1'b1;
      end else if (we_clr && wdata[0]) begin
        irq_reg <= 1'b0;
      end
    end
  end

  assign tcfg  = tcfg_reg;
  assign tval  = tval_reg;
  assign presc = presc_reg;
  assign irq   = irq_reg;

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of countdown timers behind a single-cycle CSR port; decodes {channel, reg} and muxes reads.
module csr_timer_bank
  import csr_timer_bank_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_W    = 32,
  parameter int PRESC_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              csr_we,
  input  logic [$clog2(NUM_TIMERS)+1:0]     csr_waddr,
  input  logic [TIMER_W-1:0]                csr_wdata,
  input  logic [$clog2(NUM_TIMERS)+1:0]     csr_raddr,
  output logic [TIMER_W-1:0]                csr_rdata,
  output logic [NUM_TIMERS-1:0]             timer_int
);

  localparam int AW = $clog2(NUM_TIMERS) + 2;

  logic [AW-1:0] wch;
  logic [AW-1:0] rch;
  csr_reg_e      wreg;
  csr_reg_e      rreg;

  logic [TIMER_W-1:0] tcfg_arr  [NUM_TIMERS];
  logic [TIMER_W-1:0] tval_arr  [NUM_TIMERS];
  logic [PRESC_W-1:0] presc_arr [NUM_TIMERS];

  assign wch  = csr_waddr >> 2;
  assign rch  = csr_raddr >> 2;
  assign wreg = csr_reg_e'(csr_waddr[1:0]);
  assign rreg = csr_reg_e'(csr_raddr[1:0]);

  // Channel indices with no instance never match, so their writes fall on the floor.
  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
    logic sel;
    assign sel = csr_we && (wch == AW'(gi));

    timer_chan #(
      .TIMER_W (TIMER_W),
      .PRESC_W (PRESC_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .we_cfg   (sel && (wreg == REG_TCFG)),
      .we_clr   (sel && (wreg == REG_TICLR)),
      .we_presc (sel && (wreg == REG_PRESC)),
      .wdata    (csr_wdata),
      .tcfg     (tcfg_arr[gi]),
      .tval     (tval_arr[gi]),
      .presc    (presc_arr[gi]),
      .irq      (timer_int[gi])
    );
  end

  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (rch == AW'(i)) begin
        case (rreg)
          REG_TCFG:  csr_rdata = tcfg_arr[i];
          REG_TVAL:  csr_rdata = tval_arr[i];
          REG_PRESC: csr_rdata = TIMER_W'(presc_arr[i]);
          default:   csr_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_timer_bank.sv
// Scoreboarded bench for csr_timer_bank: directed timing scenarios plus random CSR traffic against a reference model.
module tb_csr_timer_bank;

  localparam int N  = 3;
  localparam int TW = 32;
  localparam int PW = 8;
  localparam int AW = $clog2(N) + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          csr_we = 1'b0;
  logic [AW-1:0] csr_waddr = '0;
  logic [TW-1:0] csr_wdata = '0;
  logic [AW-1:0] csr_raddr = '0;
  logic [TW-1:0] csr_rdata;
  logic [N-1:0]  timer_int;

  csr_timer_bank #(
    .NUM_TIMERS (N),
    .TIMER_W    (TW),
    .PRESC_W    (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .csr_we    (csr_we),
    .csr_waddr (csr_waddr),
    .csr_wdata (csr_wdata),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .timer_int (timer_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] rdata;
    logic [N-1:0]  irq;
    logic [AW-1:0] ra;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise_cnt  [N];
  int   last_rise [N];
  int   prev_rise [N];
  logic [N-1:0] irq_seen = '0;

  // Reference model: per-channel architectural state, advanced once per clock edge.
  logic [TW-1:0] m_cfg   [N];
  logic [TW-1:0] m_tval  [N];
  int            m_presc [N];
  int            m_phase [N];
  bit            m_run   [N];
  bit            m_irq   [N];

  function automatic logic [AW-1:0] A(input int ch, input int r);
    return AW'(ch * 4 + r);
  endfunction

  function automatic logic [TW-1:0] model_read(input logic [AW-1:0] a);
    int ch;
    logic [1:0] r;
    ch = int'(a >> 2);
    r  = a[1:0];
    if (ch >= N) return '0;
    case (r)
      2'd0:    return m_cfg[ch];
      2'd1:    return m_tval[ch];
      2'd3:    return TW'(m_presc[ch]);
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] model_irq();
    logic [N-1:0] v;
    for (int ch = 0; ch < N; ch++) v[ch] = m_irq[ch];
    return v;
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [AW-1:0] wa,
                            input logic [TW-1:0] wd);
    for (int ch = 0; ch < N; ch++) begin
      bit mine;
      int r;
      bit tick;
      bit expire;
      mine   = we && (int'(wa >> 2) == ch);
      r      = int'(wa[1:0]);
      tick   = m_run[ch] && (m_phase[ch] == m_presc[ch]);
      expire = tick && (m_tval[ch] == 0);
      if (rst) begin
        m_cfg[ch] = '0; m_tval[ch] = '0; m_presc[ch] = 0;
        m_phase[ch] = 0; m_run[ch] = 0; m_irq[ch] = 0;
      end else begin
        if (mine && r == 0) begin
          m_cfg[ch]   = wd;
          m_tval[ch]  = (wd >> 2) * 4;
          m_phase[ch] = 0;
          m_run[ch]   = wd[0];
        end else if (m_run[ch]) begin
          m_phase[ch] = tick ? 0 : (m_phase[ch] + 1) % (1 << PW);
          if (tick) begin
            if (m_tval[ch] != 0) begin
              m_tval[ch] = m_tval[ch] - 1;
            end else begin
              m_irq[ch] = 1;
              if (m_cfg[ch][1]) m_tval[ch] = (m_cfg[ch] >> 2) * 4;
              else begin
                m_tval[ch] = {TW{1'b1}};
                m_run[ch]  = 0;
              end
            end
          end
        end
        if (mine && r == 2 && wd[0] && !expire) m_irq[ch] = 0;
        if (mine && r == 3) m_presc[ch] = int'(wd[PW-1:0]);
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // One clock cycle of stimulus; entered and left #1 after a rising edge.
  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [TW-1:0] wd,
                      input logic [AW-1:0] ra);
    exp_t e;
    csr_we    = we;
    csr_waddr = wa;
    csr_wdata = wd;
    csr_raddr = ra;
    e.rdata = model_read(ra);
    e.irq   = model_irq();
    e.ra    = ra;
    e.cyc   = cyc;
    exp_q.push_back(e);
    model_edge(reset, we, wa, wd);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic [AW-1:0] ra);
    step(1'b0, '0, '0, ra);
  endtask

  task automatic wait_rise(input int ch, input int budget, input logic [AW-1:0] ra,
                           output int rc);
    int start;
    int n;
    start = rise_cnt[ch];
    n = 0;
    while (rise_cnt[ch] == start && n < budget) begin
      idle(ra);
      n++;
    end
    check($sformatf("rise_seen_ch%0d", ch), longint'(rise_cnt[ch] != start), 1);
    rc = last_rise[ch];
  endtask

  // Monitor: compares every cycle's read data and interrupt lines, and logs interrupt rises.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (csr_rdata !== mon_e.rdata) begin
        n_fail++;
        $display("FAIL rdata cyc=%0d raddr=%0d: got %h, expected %h",
                 mon_e.cyc, mon_e.ra, csr_rdata, mon_e.rdata);
      end
      n_checks++;
      if (timer_int !== mon_e.irq) begin
        n_fail++;
        $display("FAIL timer_int cyc=%0d: got %b, expected %b", mon_e.cyc, timer_int, mon_e.irq);
      end
    end
    for (int ch = 0; ch < N; ch++) begin
      if (timer_int[ch] === 1'b1 && irq_seen[ch] !== 1'b1) begin
        prev_rise[ch] = last_rise[ch];
        last_rise[ch] = cyc;
        rise_cnt[ch]++;
      end
    end
    irq_seen = timer_int;
  end

  task automatic run_all();
    int c, r1, r2, s0, s1, n, cnt_before;

    repeat (2) @(posedge clk);
    #1;
    model_edge(1'b1, 1'b0, '0, '0);
    reset = 1'b0;
    check("reset_timer_int", longint'(timer_int), 0);
    for (int a = 0; a < (1 << AW); a++) idle(AW'(a));

    // Periodic, InitVal=3
    c = cyc;
    step(1'b1, A(0, 0), (3 << 2) | 3, A(0, 1));
    wait_rise(0, 40, A(0, 1), r1);
    check("periodic_first_rise", r1 - c, 14);
    step(1'b1, A(0, 2), 1, A(0, 1));
    wait_rise(0, 40, A(0, 1), r2);
    check("periodic_period", r2 - r1, 13);
    step(1'b1, A(0, 0), 0, A(0, 0));
    step(1'b1, A(0, 2), 1, A(0, 0));

    // One-shot, InitVal=2
    c = cyc;
    step(1'b1, A(0, 0), (2 << 2) | 1, A(0, 1));
    wait_rise(0, 40, A(0, 1), r1);
    check("oneshot_rise", r1 - c, 10);
    step(1'b1, A(0, 2), 1, A(0, 1));
    cnt_before = rise_cnt[0];
    repeat (50) idle(A(0, 1));
    check("oneshot_tval_held", longint'(csr_rdata), longint'(32'hFFFF_FFFF));
    check("oneshot_no_rerise", rise_cnt[0] - cnt_before, 0);
    step(1'b1, A(0, 0), 0, A(0, 1));

    // Prescaler 3, InitVal=1 periodic
    step(1'b1, A(0, 3), 3, A(0, 3));
    c = cyc;
    step(1'b1, A(0, 0), (1 << 2) | 3, A(0, 1));
    wait_rise(0, 60, A(0, 1), r1);
    check("presc_rise", r1 - c, 21);
    step(1'b1, A(0, 0), 0, A(0, 1));
    step(1'b1, A(0, 2), 1, A(0, 1));
    step(1'b1, A(0, 3), 0, A(0, 3));

    // TICLR in the expiry cycle (InitVal=1, expiries end of c+5 and c+10)
    c = cyc;
    step(1'b1, A(0, 0), (1 << 2) | 3, A(0, 1));
    while (cyc < c + 10) idle(A(0, 1));
    step(1'b1, A(0, 2), 1, A(0, 1));
    check("ticlr_vs_expiry_set_wins", longint'(timer_int[0]), 1);
    step(1'b1, A(0, 2), 1, A(0, 1));
    check("ticlr_plain_clear", longint'(timer_int[0]), 0);

    // TCFG rewrite in the expiry cycle (end of c+15)
    while (cyc < c + 15) idle(A(0, 1));
    step(1'b1, A(0, 0), (6 << 2) | 3, A(0, 1));
    check("tcfg_vs_expiry_no_irq", longint'(timer_int[0]), 0);
    check("tcfg_vs_expiry_reload", longint'(csr_rdata), 24);
    step(1'b1, A(0, 0), 0, A(0, 1));
    step(1'b1, A(0, 2), 1, A(0, 1));

    // Two channels, periods 9 and 21, with ch1 writes interleaved
    s0 = rise_cnt[0];
    s1 = rise_cnt[1];
    step(1'b1, A(0, 0), (2 << 2) | 3, A(0, 1));
    step(1'b1, A(1, 0), (5 << 2) | 3, A(0, 1));
    n = 0;
    while (rise_cnt[1] < s1 + 2 && n < 120) begin
      step(1'b1, A(n % 2, 2), 1, A(0, 1));
      n++;
    end
    check("multi_ch1_two_rises", longint'(rise_cnt[1] >= s1 + 2), 1);
    check("multi_ch1_period", last_rise[1] - prev_rise[1], 21);
    check("multi_ch0_two_rises", longint'(rise_cnt[0] >= s0 + 2), 1);
    check("multi_ch0_period", last_rise[0] - prev_rise[0], 9);

    // Reset while ch0 shows TVAL=7 with its interrupt pending
    step(1'b1, A(0, 0), 0, A(0, 1));
    step(1'b1, A(0, 2), 1, A(0, 1));
    step(1'b1, A(0, 0), (2 << 2) | 3, A(0, 1));
    wait_rise(0, 40, A(0, 1), r1);
    check("pre_reset_tval", longint'(csr_rdata), 7);
    check("pre_reset_irq", longint'(timer_int[0]), 1);
    reset = 1'b1;
    step(1'b1, A(1, 0), 32'h1F, A(0, 1));
    reset = 1'b0;
    check("post_reset_irq", longint'(timer_int), 0);
    check("post_reset_tval", longint'(csr_rdata), 0);
    for (int a = 0; a < (1 << AW); a++) idle(AW'(a));
    repeat (10) idle(A(0, 1));
    check("post_reset_no_count", longint'(csr_rdata), 0);

    // Random CSR traffic, including unmapped channel 3 and TVAL writes
    for (int i = 0; i < 3000; i++) begin
      bit            we;
      logic [AW-1:0] wa;
      logic [TW-1:0] wd;
      int            ch;
      we = ($urandom_range(0, 3) == 0);
      wa = AW'($urandom);
      ch = int'(wa >> 2);
      case (wa[1:0])
        2'd0:    wd = TW'(($urandom_range(0, 6) << 2) | $urandom_range(0, 3));
        2'd2:    wd = TW'($urandom_range(0, 1));
        2'd3:    wd = TW'($urandom_range(0, 3));
        default: wd = TW'($urandom);
      endcase
      // Only retime a prescaler that is not currently counting.
      if (wa[1:0] == 2'd3 && ch < N && m_run[ch]) wa[1:0] = 2'd1;
      if ($urandom_range(0, 699) == 0) reset = 1'b1;
      step(we, wa, wd, AW'($urandom));
      reset = 1'b0;
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    run_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
